cordic_gain_compensator: RTL

//  Downstream stage of the CORDIC vectoring core. Captures the final x (raw magnitude)
//  and z (angle) when the core's done output rises. Removes the CORDIC gain by

---
 rtl/cordic_gain_compensator.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cordic_gain_compensator.sv
// ============================================================================
// cordic_gain_compensator : removes CORDIC gain from vectoring magnitude with a
// bit-serial shift-add multiply; valid/ready result port.   Rev 1.0
// ============================================================================
`default_nettype none

module cordic_gain_compensator #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    GAIN_WIDTH = 16,
  parameter logic [GAIN_WIDTH-1:0] GAIN       = 16'h4DBA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cordic_done,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] z_in,
  input  logic                  out_ready,
  input  logic                  clr_overrun,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] mag_out,
  output logic [DATA_WIDTH-1:0] angle_out,
  output logic                  busy,
  output logic                  overrun
);

  localparam int               ACC_W    = DATA_WIDTH + GAIN_WIDTH;
  localparam int               CNT_W    = (GAIN_WIDTH > 1) ? $clog2(GAIN_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GAIN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  done_q;
  logic                  done_rise;
  logic                  handshake;
  logic                  capture;
  logic                  overrun_set;
  logic                  mul_last;
  logic [DATA_WIDTH-1:0] x_r;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      partial;
  logic [ACC_W-1:0]      acc_next;
  logic [CNT_W-1:0]      cnt;

  // done_q resets high so a core idling with done=1 is not mistaken for a new result
  assign done_rise = cordic_done & ~done_q;
  assign handshake = out_valid & out_ready;
  assign mul_last  = (state == MUL) && (cnt == LAST_CNT);
  assign partial   = GAIN[cnt] ? (ACC_W'(x_r) << cnt) : '0;
  assign acc_next  = acc + partial;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (done_rise) begin
          capture    = 1'b1;
          state_next = MUL;
        end
      end
      MUL: begin
        if (done_rise) begin
          overrun_set = 1'b1;
        end
        if (cnt == LAST_CNT) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          if (done_rise) begin
            capture    = 1'b1;
            state_next = MUL;
          end else begin
            state_next = IDLE;
          end
        end else if (done_rise) begin
          overrun_set = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q    <= 1'b1;
      x_r       <= '0;
      acc       <= '0;
      cnt       <= '0;
      mag_out   <= '0;
      angle_out <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done_q <= cordic_done;

      if (capture) begin
        x_r       <= x_in;
        angle_out <= z_in;
        acc       <= '0;
        cnt       <= '0;
      end else if (state == MUL) begin
        acc <= acc_next;
        cnt <= cnt + CNT_W'(1);
      end

      // The last partial product is folded in on the same edge the result is published
      if (mul_last) begin
        mag_out <= acc_next[ACC_W-2:GAIN_WIDTH-1];
      end

      if (mul_last) begin
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end

      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
